// File: rtl/fold_issue_ctl.sv
`default_nettype none
// ============================================================================
// Module   : fold_issue_ctl
// Purpose  : Sequences the instruction folder between the instruction buffer
//            and decode, with post-flush quiet period and consistency checks.
// Revision : 1.0 - initial release
// ============================================================================
module fold_issue_ctl #(
    parameter int QUIET_GROUPS = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fold_en_cfg,
    input  logic             single_step,
    input  logic             flush,
    input  logic             hold,
    input  logic [3:0]       ibuf_valid,
    input  logic             fold1,
    input  logic             fold2,
    input  logic             fold3,
    input  logic             fold4,
    input  logic             notvalid,
    output logic             foe,
    output logic [2:0]       ibuf_shift,
    output logic             issue_valid,
    output logic [2:0]       issue_cnt,
    output logic             fold_err,
    output logic [CNT_W-1:0] fold_groups
);

    localparam int QW = (QUIET_GROUPS > 0) ? $clog2(QUIET_GROUPS + 1) : 1;
    localparam logic [QW-1:0] QUIET_LOAD = QW'(QUIET_GROUPS);

    localparam logic [1:0] S_RST   = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic             valid_q, valid_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] groups_q, groups_d;

    logic       w_run;
    logic       w_foe;
    logic [2:0] w_k;
    logic       w_accept;
    logic       w_err_now;
    logic [2:0] w_nfold;

    assign w_run = (state_q == S_RUN);
    assign w_foe = fold_en_cfg & ~single_step & w_run & (quiet_q == '0);

    always_comb begin
        w_k = 3'd0;
        if (fold4)      w_k = 3'd4;
        else if (fold3) w_k = 3'd3;
        else if (fold2) w_k = 3'd2;
        else if (fold1) w_k = 3'd1;
    end

    // An accept with no fold decision is not an accept at all.
    assign w_accept = w_run & ~flush & ~notvalid & ~(valid_q & hold) & (w_k != 3'd0);

    assign w_nfold = {2'b00, fold1} + {2'b00, fold2} + {2'b00, fold3} + {2'b00, fold4};

    always_comb begin
        w_err_now = 1'b0;
        if (w_nfold > 3'd1)                             w_err_now = 1'b1;
        if (fold1 & ~ibuf_valid[0])                     w_err_now = 1'b1;
        if (fold2 & ~(&ibuf_valid[1:0]))                w_err_now = 1'b1;
        if (fold3 & ~(&ibuf_valid[2:0]))                w_err_now = 1'b1;
        if (fold4 & ~(&ibuf_valid[3:0]))                w_err_now = 1'b1;
        if ((fold2 | fold3 | fold4) & ~w_foe)           w_err_now = 1'b1;
        if (notvalid != ~ibuf_valid[0])                 w_err_now = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        quiet_d  = quiet_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        err_d    = err_q | (w_run & w_err_now);
        groups_d = groups_q;

        case (state_q)
            S_RST:   state_d = S_RUN;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase

        if (flush) begin
            state_d = S_FLUSH;
            valid_d = 1'b0;
            quiet_d = QUIET_LOAD;
        end else if (w_accept) begin
            valid_d = 1'b1;
            cnt_d   = w_k;
            if (quiet_q != '0) quiet_d = quiet_q - 1'b1;
            if ((w_k >= 3'd2) && (groups_q != {CNT_W{1'b1}})) groups_d = groups_q + 1'b1;
        end else if (~hold) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RST;
            quiet_q  <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= 3'd0;
            err_q    <= 1'b0;
            groups_q <= '0;
        end else begin
            state_q  <= state_d;
            quiet_q  <= quiet_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            groups_q <= groups_d;
        end
    end

    assign foe         = w_foe;
    assign ibuf_shift  = w_accept ? w_k : 3'd0;
    assign issue_valid = valid_q;
    assign issue_cnt   = cnt_q;
    assign fold_err    = err_q;
    assign fold_groups = groups_q;

endmodule
`default_nettype wire

// File: tb/tb_fold_issue_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fold_issue_ctl
// Purpose  : Directed self-checking bench for fold_issue_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fold_issue_ctl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             fold_en_cfg, single_step, flush, hold;
    logic [3:0]       ibuf_valid;
    logic             fold1, fold2, fold3, fold4, notvalid;
    logic             foe;
    logic [2:0]       ibuf_shift;
    logic             issue_valid;
    logic [2:0]       issue_cnt;
    logic             fold_err;
    logic [CNT_W-1:0] fold_groups;

    int n_checks = 0;
    int n_errors = 0;

    fold_issue_ctl #(.QUIET_GROUPS(2), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .fold_en_cfg(fold_en_cfg),
        .single_step(single_step), .flush(flush), .hold(hold),
        .ibuf_valid(ibuf_valid), .fold1(fold1), .fold2(fold2),
        .fold3(fold3), .fold4(fold4), .notvalid(notvalid),
        .foe(foe), .ibuf_shift(ibuf_shift), .issue_valid(issue_valid),
        .issue_cnt(issue_cnt), .fold_err(fold_err), .fold_groups(fold_groups)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fold(input logic [3:0] f);
        {fold4, fold3, fold2, fold1} = f;
        #1;
    endtask

    initial begin
        reset = 1'b1; fold_en_cfg = 1'b1; single_step = 1'b0; flush = 1'b0;
        hold = 1'b0; ibuf_valid = 4'hF; notvalid = 1'b0;
        {fold4, fold3, fold2, fold1} = 4'b0100;

        tick(); tick();
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_cnt", 32'(issue_cnt), 32'd0);
        chk("rst_err", 32'(fold_err), 32'd0);
        chk("rst_groups", 32'(fold_groups), 32'd0);
        chk("rst_foe", 32'(foe), 32'd0);
        chk("rst_shift", 32'(ibuf_shift), 32'd0);

        // Test 1: first cycle after release is still RST
        reset = 1'b0; #1;
        chk("t1_c1_foe", 32'(foe), 32'd0);
        chk("t1_c1_shift", 32'(ibuf_shift), 32'd0);
        tick();
        chk("t1_c2_foe", 32'(foe), 32'd1);
        chk("t1_c2_shift", 32'(ibuf_shift), 32'd3);
        chk("t1_c2_valid", 32'(issue_valid), 32'd0);
        tick();
        chk("t1_c3_valid", 32'(issue_valid), 32'd1);
        chk("t1_c3_cnt", 32'(issue_cnt), 32'd3);
        chk("t1_c3_groups", 32'(fold_groups), 32'd1);

        // Test 2: hold stalls the issue register
        hold = 1'b1; set_fold(4'b0010);
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_shift", 32'(ibuf_shift), 32'd0);
            tick();
            chk("t2_hold_cnt", 32'(issue_cnt), 32'd3);
            chk("t2_hold_valid", 32'(issue_valid), 32'd1);
        end
        hold = 1'b0; #1;
        chk("t2_release_shift", 32'(ibuf_shift), 32'd2);
        tick();
        chk("t2_cnt", 32'(issue_cnt), 32'd2);
        chk("t2_groups", 32'(fold_groups), 32'd2);

        // Test 3: flush beats hold and a valid accept, then quiet period
        hold = 1'b1; flush = 1'b1; set_fold(4'b0001);
        chk("t3_flush_shift", 32'(ibuf_shift), 32'd0);
        tick();
        flush = 1'b0; #1;
        chk("t3_fl_valid", 32'(issue_valid), 32'd0);
        chk("t3_fl_foe", 32'(foe), 32'd0);
        chk("t3_fl_shift", 32'(ibuf_shift), 32'd0);
        chk("t3_fl_groups", 32'(fold_groups), 32'd2);
        hold = 1'b0;
        tick();
        chk("t3_q1_foe", 32'(foe), 32'd0);
        chk("t3_q1_shift", 32'(ibuf_shift), 32'd1);
        tick();
        chk("t3_q2_foe", 32'(foe), 32'd0);
        chk("t3_q2_valid", 32'(issue_valid), 32'd1);
        chk("t3_q2_cnt", 32'(issue_cnt), 32'd1);
        tick();
        chk("t3_after_foe", 32'(foe), 32'd1);
        chk("t3_err", 32'(fold_err), 32'd0);

        // Test 6: single-step disables folding
        single_step = 1'b1; #1;
        chk("t6_foe", 32'(foe), 32'd0);
        chk("t6_shift", 32'(ibuf_shift), 32'd1);
        tick(); tick();
        chk("t6_cnt", 32'(issue_cnt), 32'd1);
        chk("t6_groups", 32'(fold_groups), 32'd2);
        chk("t6_noerr", 32'(fold_err), 32'd0);
        set_fold(4'b0010);
        tick();
        chk("t6_err", 32'(fold_err), 32'd1);
        single_step = 1'b0; set_fold(4'b0000);

        // Reset clears the sticky error and counters
        reset = 1'b1;
        tick();
        chk("rst2_err", 32'(fold_err), 32'd0);
        chk("rst2_groups", 32'(fold_groups), 32'd0);
        reset = 1'b0; set_fold(4'b0010);
        tick();

        // Test 4: counter saturation at 15
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 13) chk("t4_groups14", 32'(fold_groups), 32'd14);
        end
        chk("t4_groups_sat", 32'(fold_groups), 32'd15);
        chk("t4_err", 32'(fold_err), 32'd0);

        // Test 5: fold4 with missing entry sets sticky error
        ibuf_valid = 4'b0111; set_fold(4'b1000);
        tick();
        chk("t5_err", 32'(fold_err), 32'd1);
        ibuf_valid = 4'hF; set_fold(4'b0001);
        tick(); tick();
        chk("t5_sticky", 32'(fold_err), 32'd1);
        chk("t5_cnt", 32'(issue_cnt), 32'd1);
        reset = 1'b1;
        tick();
        chk("t5_rst_err", 32'(fold_err), 32'd0);
        chk("t5_rst_valid", 32'(issue_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fold_issue_ctl.md
Name: fold_issue_ctl

Overview:
Sequences the instruction-folding decoder between the instruction buffer and the decode/issue stage.
- Drives the folder's fold-enable (FOE).
- Accepts the folder's group decision (fold1..fold4) and tells the instruction buffer how many entries to shift out.
- Registers the issued group toward decode with a hold handshake.
- Forces unfolded issue for a programmable number of groups after every pipeline flush, flags inconsistent folder outputs, and counts folded groups.

Parameters:
QUIET_GROUPS, 2, number of accepted groups after a flush that must issue with FOE low (0 disables quiet period)
CNT_W, 16, width of saturating folded-group counter

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
fold_en_cfg  input  1  folding globally enabled (PSR fold bit)
single_step  input  1  debug single-step; forces FOE low while 1
flush  input  1  pipeline flush / taken branch; priority over everything except reset
hold  input  1  decode stage stall; issue register must stay stable while 1
ibuf_valid  input  4  V0..V3 entry-valid bits of instruction buffer (bit0 = oldest)
fold1  input  1  folder: issue 1 instruction
fold2  input  1  folder: issue 2-instruction group
fold3  input  1  folder: issue 3-instruction group
fold4  input  1  folder: issue 4-instruction group
notvalid  input  1  folder: entry 0 not valid
foe  output  1  fold enable to folder
ibuf_shift  output  3  entries consumed this cycle (0-4), combinational
issue_valid  output  1  registered group valid to decode
issue_cnt  output  3  registered instructions in group (1-4)
fold_err  output  1  sticky error: inconsistent folder outputs
fold_groups  output  CNT_W  saturating count of accepted groups with issue_cnt>=2

Behaviour:
- States: RST, RUN, FLUSH. Encoding is free; state is not exported.
- Reset (synchronous):
  - State goes to RST.
  - issue_valid=0, issue_cnt=0, fold_err=0, fold_groups=0, quiet_cnt=0.
  - Outputs foe=0 and ibuf_shift=0 during RST.
- RST -> RUN unconditionally on the next cycle. No acceptance occurs in RST.
- flush=1 in any non-reset state:
  - Next state is FLUSH.
  - issue_valid is cleared at the next edge, even if hold=1.
  - quiet_cnt is loaded with QUIET_GROUPS.
  - ibuf_shift=0 that cycle.
- FLUSH -> RUN next cycle (one bubble). No acceptance in FLUSH. foe=0 in FLUSH.
- foe = fold_en_cfg & ~single_step & (state==RUN) & (quiet_cnt==0).
- Accept condition (combinational): state==RUN & ~flush & ~notvalid & ~(issue_valid & hold).
- Accepted count k:
  - k=4 if fold4, else 3 if fold3, else 2 if fold2, else 1 if fold1, else 0.
  - ibuf_shift=k when accepting, else 0.
  - An accept with k=0 is treated as no accept.
- On an accept with k>0:
  - issue_valid<=1, issue_cnt<=k.
  - quiet_cnt decrements if nonzero.
  - fold_groups increments if k>=2, saturating at all-ones.
- Not accepting, with issue_valid & hold: issue_valid and issue_cnt hold their values.
- Not accepting, with ~hold: issue_valid<=0. issue_cnt holds its value (don't-care when invalid).
- Latency: folder decision to issue_valid is 1 cycle. Throughput is one group per cycle when hold=0.
- fold_err is set (sticky until reset) in RUN on any of:
  - more than one of fold1..fold4 high;
  - foldN high with any of ibuf_valid[N-1:0] low;
  - fold2/3/4 high while foe=0;
  - notvalid != ~ibuf_valid[0].
- fold_err is checked regardless of hold. Error-free operation continues.
- Simultaneous flush and hold: flush wins.
- Simultaneous flush and an otherwise-valid accept: no accept, counters unchanged.
- Reset mid-group discards everything. No partial state survives.

Test Plan:
1. Reset held 2 cycles, then released; fold_en_cfg=1, ibuf_valid=4'hF, fold3=1 → cycle 1 after release RST (foe=0, shift=0); cycle 2 foe=1, ibuf_shift=3; cycle 3 issue_valid=1, issue_cnt=3, fold_groups=1.
2. In RUN with issue_valid=1, hold=1 for 3 cycles, fold2=1 → ibuf_shift=0 all 3 cycles and issue_cnt stays unchanged; hold drops → ibuf_shift=2 same cycle; issue_cnt=2 next cycle.
3. flush pulse with hold=1 and issue_valid=1 → next cycle issue_valid=0, state FLUSH, foe=0; following cycle RUN with foe=0 for 2 accepted fold1 groups (QUIET_GROUPS=2), then foe=1.
4. fold_groups preloaded near saturation via CNT_W=4 build: 17 consecutive fold2 accepts → fold_groups=15 and stays 15.
5. fold4=1 with ibuf_valid=4'b0111 → fold_err=1 next cycle and remains 1 after inputs are corrected; clears only on reset.
6. single_step=1 with fold_en_cfg=1 → foe=0; fold1 accepts give issue_cnt=1 each cycle, fold_groups unchanged; fold2 asserted under foe=0 → fold_err=1.
